// File: rtl/qsys_serial_pkg.sv
// Shared definitions for the Qsys serial link: frame geometry, FSM encoding and frame packing.
package qsys_serial_pkg;

  localparam int unsigned FRAME_W      = 65;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned FRAME_ADDR_W = 32;
  localparam int unsigned RW_BIT       = 64;
  localparam int unsigned CNT_W        = 7;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSend    = 3'd1,
    StWaitRdy = 3'd2,
    StCapture = 3'd3,
    StDone    = 3'd4,
    StGap     = 3'd5
  } qsys_state_e;

  function automatic logic [FRAME_W-1:0] build_frame(input logic                    rw,
                                                     input logic [FRAME_ADDR_W-1:0] addr,
                                                     input logic [DATA_W-1:0]       data);
    logic [FRAME_W-1:0] f;
    f                            = '0;
    f[RW_BIT]                    = rw;
    f[RW_BIT-1 -: FRAME_ADDR_W]  = addr;
    f[DATA_W-1:0]                = data;
    return f;
  endfunction

endpackage

// File: rtl/qsys_serial_shifter.sv
// Loadable 65-bit PISO for the outgoing frame, 32-bit SIPO for the return word, shared bit counter.
module qsys_serial_shifter
  import qsys_serial_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [FRAME_W-1:0] frame_i,
  input  logic               shift_i,
  input  logic               cap_clr_i,
  input  logic               cap_en_i,
  input  logic               sin_i,
  output logic               sout_o,
  output logic [DATA_W-1:0]  cap_word_o,
  output logic [CNT_W-1:0]   cnt_o
);

  logic [FRAME_W-1:0] piso_q, piso_d;
  logic [DATA_W-1:0]  sipo_q, sipo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    piso_d = piso_q;
    sipo_d = sipo_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      piso_d = frame_i;
    end else if (shift_i) begin
      piso_d = {piso_q[FRAME_W-2:0], 1'b0};
    end
    if (cap_clr_i) begin
      sipo_d = '0;
    end else if (cap_en_i) begin
      sipo_d = {sipo_q[DATA_W-2:0], sin_i};
    end
    // One counter serves both directions; a load or capture-clear restarts it.
    if (load_i || cap_clr_i) begin
      cnt_d = '0;
    end else if (shift_i || cap_en_i) begin
      cnt_d = cnt_q + 7'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      piso_q <= '0;
      sipo_q <= '0;
      cnt_q  <= '0;
    end else begin
      piso_q <= piso_d;
      sipo_q <= sipo_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sout_o     = piso_q[FRAME_W-1];
  assign cap_word_o = sipo_q;
  assign cnt_o      = cnt_q;

endmodule

// File: rtl/qsys_serial_client.sv
// Avalon-MM slave that turns each bus access into one serial frame and waits for the host's reply.
module qsys_serial_client
  import qsys_serial_pkg::*;
#(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned TIMEOUT      = 1024,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic              csi_MCLK_clk,
  input  logic              rsi_MRST_reset,
  input  logic [ADDR_W-1:0] avs_S1_address,
  input  logic              avs_S1_read,
  input  logic              avs_S1_write,
  input  logic [31:0]       avs_S1_writedata,
  output logic [31:0]       avs_S1_readdata,
  output logic              avs_S1_waitrequest,
  output logic              sclk,
  output logic              sle,
  output logic              sdi,
  input  logic              sdo,
  input  logic              srdy,
  output logic              timeout_flag
);

  localparam int unsigned CntMax = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int unsigned TW     = $clog2(CntMax + 1);

  qsys_state_e       state_q, state_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              sle_q, sle_d;
  logic              sdi_q, sdi_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              wait_q, wait_d;
  logic              flag_q, flag_d;
  logic              rw_q, rw_d;

  logic              load, shift, cap_clr, cap_en, sout;
  logic [DATA_W-1:0] cap_word;
  logic [CNT_W-1:0]  cnt;
  logic [FRAME_W-1:0] frame;

  assign frame = build_frame(avs_S1_write, FRAME_ADDR_W'(avs_S1_address),
                             avs_S1_write ? avs_S1_writedata : '0);

  qsys_serial_shifter u_shifter (
    .clk_i      (csi_MCLK_clk),
    .rst_i      (rsi_MRST_reset),
    .load_i     (load),
    .frame_i    (frame),
    .shift_i    (shift),
    .cap_clr_i  (cap_clr),
    .cap_en_i   (cap_en),
    .sin_i      (sdo),
    .sout_o     (sout),
    .cap_word_o (cap_word),
    .cnt_o      (cnt)
  );

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    sle_d   = 1'b0;
    sdi_d   = 1'b0;
    rdata_d = rdata_q;
    flag_d  = flag_q;
    rw_d    = rw_q;
    load    = 1'b0;
    shift   = 1'b0;
    cap_clr = 1'b0;
    cap_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (avs_S1_read || avs_S1_write) begin
          load    = 1'b1;
          rw_d    = avs_S1_write;
          sle_d   = 1'b1;
          state_d = StSend;
        end
      end
      StSend: begin
        // Outputs are registered, so S(k) presents the bit chosen while in S(k-1).
        if (cnt < CNT_W'(FRAME_W)) begin
          shift = 1'b1;
          sdi_d = sout;
          sle_d = (cnt < CNT_W'(FRAME_W - 1));
        end else begin
          tmo_d   = '0;
          state_d = StWaitRdy;
        end
      end
      StWaitRdy: begin
        if (srdy) begin
          cap_clr = 1'b1;
          state_d = StCapture;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          rdata_d = TIMEOUT_DATA;
          flag_d  = 1'b1;
          state_d = StDone;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StCapture: begin
        if (cnt == CNT_W'(DATA_W)) begin
          if (!rw_q) rdata_d = cap_word;
          state_d = StDone;
        end else if (srdy) begin
          cap_en = 1'b1;
        end else begin
          rdata_d = TIMEOUT_DATA;
          flag_d  = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        tmo_d   = '0;
        state_d = (GAP_CYCLES == 0) ? StIdle : StGap;
      end
      StGap: begin
        if (tmo_q == TW'(GAP_CYCLES - 1)) begin
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    wait_d = (state_d != StDone);
  end

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      state_q <= StIdle;
      tmo_q   <= '0;
      sle_q   <= 1'b0;
      sdi_q   <= 1'b0;
      rdata_q <= '0;
      wait_q  <= 1'b1;
      flag_q  <= 1'b0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      sle_q   <= sle_d;
      sdi_q   <= sdi_d;
      rdata_q <= rdata_d;
      wait_q  <= wait_d;
      flag_q  <= flag_d;
      rw_q    <= rw_d;
    end
  end

  assign sclk               = csi_MCLK_clk;
  assign sle                = sle_q;
  assign sdi                = sdi_q;
  assign avs_S1_readdata    = rdata_q;
  assign avs_S1_waitrequest = wait_q;
  assign timeout_flag       = flag_q;

endmodule

// File: tb/tb_qsys_serial_client.sv
// Bench for qsys_serial_client: Avalon master plus a serial host model driven from random data.
module tb_qsys_serial_client;

  localparam int unsigned TMO = 16;
  localparam int unsigned GAP = 2;
  localparam logic [31:0] DEAD = 32'hDEAD_BEEF;
  localparam int MFull = 0;
  localparam int MNone = 1;
  localparam int MDrop = 2;
  localparam int MRst  = 3;

  logic        clk, rst;
  logic [7:0]  address;
  logic        read, write;
  logic [31:0] writedata, readdata;
  logic        waitreq, sclk_w, sle, sdi, sdo, srdy, tflag;

  int total, bad, cyc, last_done;
  logic [31:0] exp_rdata;
  logic        exp_flag;

  qsys_serial_client #(
    .ADDR_W       (8),
    .TIMEOUT      (TMO),
    .TIMEOUT_DATA (DEAD),
    .GAP_CYCLES   (GAP)
  ) dut (
    .csi_MCLK_clk       (clk),
    .rsi_MRST_reset     (rst),
    .avs_S1_address     (address),
    .avs_S1_read        (read),
    .avs_S1_write       (write),
    .avs_S1_writedata   (writedata),
    .avs_S1_readdata    (readdata),
    .avs_S1_waitrequest (waitreq),
    .sclk               (sclk_w),
    .sle                (sle),
    .sdi                (sdi),
    .sdo                (sdo),
    .srdy               (srdy),
    .timeout_flag       (tflag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [64:0] got, input logic [64:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One Avalon access with the host model answering according to mode.
  task automatic run_xfer(input bit do_wr, input bit do_rd, input logic [7:0] addr,
                          input logic [31:0] wdata, input logic [31:0] word, input int mode,
                          input bit keep_req, input bit b2b);
    logic [64:0] exp_frame, got_frame;
    int n_hi, nbits, f, t_ta, ridx, nresp, exp_lat, rise;
    bit prev_sle, done;
    exp_frame = {do_wr, 24'h0, addr, do_wr ? wdata : 32'h0};
    got_frame = '0;
    n_hi = 0; nbits = 0; f = -1; rise = 0; prev_sle = 0; done = 0;
    t_ta  = $urandom_range(6, 10);
    nresp = (mode == MFull) ? 33 : (mode == MDrop) ? 11 : 0;
    exp_lat = (mode == MFull) ? t_ta + 34 : (mode == MDrop) ? t_ta + 12 : int'(TMO) + 1;
    read = do_rd; write = do_wr; address = addr; writedata = wdata;
    for (int j = 0; j < 400 && !done; j++) begin
      @(negedge clk);
      if (sle) begin
        n_hi++;
        if (n_hi == 1) begin
          rise = cyc;
          check_eq("s0_sdi", 65'(sdi), 65'(0));
          if (b2b) check_eq("b2b_gap", 65'(rise - last_done >= int'(GAP) + 1), 65'(1));
        end else begin
          got_frame = {got_frame[63:0], sdi};
          nbits++;
        end
        if (mode == MRst && n_hi == 31) begin
          rst = 1'b1;
          #1;
          check_eq("rst_sle", 65'(sle), 65'(0));
          check_eq("rst_wait", 65'(waitreq), 65'(1));
          read = 0; write = 0; srdy = 0;
          return;
        end
      end else if (prev_sle) begin
        got_frame = {got_frame[63:0], sdi};
        nbits++;
        f = j;
        check_eq("sle_len", 65'(n_hi), 65'(65));
        check_eq("nbits", 65'(nbits), 65'(65));
        check_eq("frame", got_frame, exp_frame);
      end
      prev_sle = sle;
      if (!waitreq) begin
        done = 1;
        check_eq("latency", 65'(j - f), 65'(exp_lat));
        if (mode == MFull) begin
          if (!do_wr) exp_rdata = word;
        end else begin
          exp_rdata = DEAD;
          exp_flag  = 1'b1;
        end
        check_eq("rdata", 65'(readdata), 65'(exp_rdata));
        check_eq("tflag", 65'(tflag), 65'(exp_flag));
        last_done = cyc;
        if (!keep_req) begin read = 0; write = 0; end
        srdy = 0;
      end else if (f < 0) begin
        // Noise the host lines while nothing should be listening to them.
        srdy = 1'($urandom);
        sdo  = 1'($urandom);
      end else begin
        ridx = j - f - t_ta;
        if (ridx >= 0 && ridx < nresp) begin
          srdy = 1'b1;
          sdo  = (ridx == 0) ? 1'($urandom) : word[32-ridx];
        end else begin
          srdy = 1'b0;
          sdo  = 1'($urandom);
        end
      end
    end
    check_eq("done_bound", 65'(done), 65'(1));
    @(negedge clk);
    check_eq("wait_once", 65'(waitreq), 65'(1));
  endtask

  initial begin
    logic        rw, rd;
    logic [7:0]  a;
    logic [31:0] d, w;
    total = 0; bad = 0; last_done = 0;
    exp_rdata = '0; exp_flag = 1'b0;
    rst = 1'b1; read = 0; write = 0; address = '0; writedata = '0; srdy = 0; sdo = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_sle", 65'(sle), 65'(0));
    check_eq("rst_sdi", 65'(sdi), 65'(0));
    check_eq("rst_rdata", 65'(readdata), 65'(0));
    check_eq("rst_wait", 65'(waitreq), 65'(1));
    check_eq("rst_flag", 65'(tflag), 65'(0));
    rst = 1'b0;
    @(negedge clk);

    run_xfer(1, 0, 8'h12, 32'hA5A5_0F0F, 32'h1357_9BDF, MFull, 0, 0);
    run_xfer(0, 1, 8'h34, 32'hFFFF_FFFF, 32'hCAFE_1234, MFull, 0, 0);
    run_xfer(0, 1, 8'h01, 32'h0, 32'h0102_0304, MFull, 1, 0);
    run_xfer(0, 1, 8'h02, 32'h0, 32'hA0B0_C0D0, MFull, 0, 1);

    for (int i = 0; i < 8; i++) begin
      rw = 1'($urandom);
      rd = rw ? 1'($urandom) : 1'b1;
      a  = 8'($urandom);
      d  = $urandom;
      w  = $urandom;
      run_xfer(rw, rd, a, d, w, MFull, 0, 0);
    end

    run_xfer(0, 1, 8'h40, 32'h0, 32'h0, MNone, 0, 0);
    run_xfer(0, 1, 8'h55, 32'h0, 32'h5A5A_1234, MFull, 0, 0);
    run_xfer(1, 0, 8'h66, 32'h0BAD_F00D, 32'h1111_2222, MNone, 0, 0);
    run_xfer(0, 1, 8'h56, 32'h0, 32'h8765_4321, MDrop, 0, 0);

    run_xfer(0, 1, 8'h77, 32'h0, 32'h2468_ACE0, MRst, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_rdata = '0;
    exp_flag  = 1'b0;
    @(negedge clk);
    check_eq("post_rst_flag", 65'(tflag), 65'(0));
    check_eq("post_rst_rdata", 65'(readdata), 65'(0));
    run_xfer(0, 1, 8'h78, 32'h0, 32'hFEED_0042, MFull, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
